// File: rtl/axis_route_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module  : axis_route_scheduler_if
//  Purpose : Route-configuration handshake plus the snooped per-source AXIS
//            handshake bits seen by the route scheduler.
//  Rev     : 1.0  initial release
// ============================================================================
interface axis_route_scheduler_if #(
  parameter int C_S_STREAM_NUM = 8,
  parameter int C_M_STREAM_NUM = 8,
  parameter int C_SRC_IDX_W    = 3
);
  logic                      cfg_wr;
  logic [C_SRC_IDX_W-1:0]    cfg_src;
  logic [C_M_STREAM_NUM-1:0] cfg_bmp;
  logic                      cfg_ack;
  logic                      cfg_err;
  logic [C_S_STREAM_NUM-1:0] s_tvalid;
  logic [C_S_STREAM_NUM-1:0] s_tuser;
  logic [C_S_STREAM_NUM-1:0] s_tready;

  // Register file / stream side drives requests and snooped handshakes
  modport master (
    output cfg_wr, cfg_src, cfg_bmp, s_tvalid, s_tuser, s_tready,
    input  cfg_ack, cfg_err
  );

  // Scheduler side
  modport slave (
    input  cfg_wr, cfg_src, cfg_bmp, s_tvalid, s_tuser, s_tready,
    output cfg_ack, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/axis_route_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : axis_route_scheduler
//  Purpose : Holds per-source destination bitmaps for the AXIS pixel
//            interconnector. New routes are validated, parked in a shadow
//            register and switched live only on a start-of-frame boundary.
//  Rev     : 1.0  initial release
// ============================================================================
module axis_route_scheduler #(
  parameter int C_S_STREAM_NUM = 8,
  parameter int C_M_STREAM_NUM = 8,
  parameter int C_ONE2MANY     = 0,
  parameter int C_SRC_IDX_W    = 3
) (
  input  wire logic                                     clk,
  input  wire logic                                     reset,
  axis_route_scheduler_if.slave                         bus,
  output logic [C_S_STREAM_NUM*C_M_STREAM_NUM-1:0]      s_dst_bmp,
  output logic [C_S_STREAM_NUM-1:0]                     pending
);

  localparam logic [C_M_STREAM_NUM-1:0] C_BMP_ONE = C_M_STREAM_NUM'(1);

  logic [C_M_STREAM_NUM-1:0] r_active [C_S_STREAM_NUM];
  logic [C_M_STREAM_NUM-1:0] r_shadow [C_S_STREAM_NUM];
  logic [C_S_STREAM_NUM-1:0] r_pending;
  logic                      r_ack;
  logic                      r_err;

  logic                      w_src_ok;
  logic                      w_bmp_ok;
  logic                      w_conflict;
  logic                      w_accept;
  logic [C_M_STREAM_NUM-1:0] w_busy;
  logic [C_S_STREAM_NUM-1:0] w_sof;
  logic [C_S_STREAM_NUM-1:0] w_commit;

  // Validate the incoming request against the pre-update route state; a
  // destination owned live or in-flight by any other source is off limits
  always_comb begin
    w_src_ok = (int'(bus.cfg_src) < C_S_STREAM_NUM);
    w_bmp_ok = (C_ONE2MANY != 0) || ((bus.cfg_bmp & (bus.cfg_bmp - C_BMP_ONE)) == '0);
    w_busy   = '0;
    for (int j = 0; j < C_S_STREAM_NUM; j++) begin
      if (j != int'(bus.cfg_src)) begin
        w_busy = w_busy | r_active[j] | (r_pending[j] ? r_shadow[j] : '0);
      end
    end
    w_conflict = ((bus.cfg_bmp & w_busy) != '0);
    w_accept   = bus.cfg_wr & w_src_ok & w_bmp_ok & ~w_conflict;
  end

  generate
    for (genvar i = 0; i < C_S_STREAM_NUM; i++) begin : g_src
      assign w_sof[i] = bus.s_tvalid[i] & bus.s_tuser[i];
      // Detached sources switch immediately; otherwise wait for an SOF
      // handshake, or for an SOF alone when the new route parks the source
      assign w_commit[i] = r_pending[i] &
                           ((r_active[i] == '0) |
                            (w_sof[i] & bus.s_tready[i]) |
                            ((r_shadow[i] == '0) & w_sof[i]));
      // Present the new route on the SOF beat itself so no beat is lost
      assign s_dst_bmp[i*C_M_STREAM_NUM +: C_M_STREAM_NUM] =
        (r_pending[i] & w_sof[i]) ? r_shadow[i] : r_active[i];
    end
  endgenerate

  // Route state: commit first, then a same-cycle accepted write re-arms the
  // shadow so the freshly committed route and the next request both survive
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_S_STREAM_NUM; i++) begin
        r_active[i] <= '0;
        r_shadow[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int i = 0; i < C_S_STREAM_NUM; i++) begin
        if (w_commit[i]) begin
          r_active[i]  <= r_shadow[i];
          r_pending[i] <= 1'b0;
        end
        if (w_accept && (int'(bus.cfg_src) == i)) begin
          r_shadow[i]  <= bus.cfg_bmp;
          r_pending[i] <= 1'b1;
        end
      end
    end
  end

  // One-cycle registered response to each write request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_accept;
      r_err <= bus.cfg_wr & ~w_accept;
    end
  end

  assign bus.cfg_ack = r_ack;
  assign bus.cfg_err = r_err;
  assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_axis_route_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_axis_route_scheduler
//  Purpose : Self-checking bench for axis_route_scheduler with a behavioural
//            route model and directed plus randomized scenarios.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_axis_route_scheduler;

  localparam int S = 8;
  localparam int M = 8;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [S*M-1:0] s_dst_bmp;
  logic [S-1:0]   pending;

  always #5 clk = ~clk;

  axis_route_scheduler_if #(.C_S_STREAM_NUM(S), .C_M_STREAM_NUM(M), .C_SRC_IDX_W(W)) bus ();

  axis_route_scheduler #(
    .C_S_STREAM_NUM(S), .C_M_STREAM_NUM(M), .C_ONE2MANY(0), .C_SRC_IDX_W(W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .s_dst_bmp(s_dst_bmp), .pending(pending)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: route tables kept as plain arrays
  logic [M-1:0] m_act [S];
  logic [M-1:0] m_shd [S];
  logic [S-1:0] m_pend;
  logic         m_ack, m_err;

  function automatic logic [S*M-1:0] exp_bmp();
    logic [S*M-1:0] v;
    v = '0;
    for (int i = 0; i < S; i++)
      v[i*M +: M] = (m_pend[i] && bus.s_tvalid[i] && bus.s_tuser[i]) ? m_shd[i] : m_act[i];
    return v;
  endfunction

  task automatic drive(input logic wr, input int src, input logic [M-1:0] bmp);
    bus.cfg_wr  = wr;
    bus.cfg_src = W'(src);
    bus.cfg_bmp = bmp;
  endtask

  task automatic snoop(input logic [S-1:0] v, input logic [S-1:0] u, input logic [S-1:0] r);
    bus.s_tvalid = v;
    bus.s_tuser  = u;
    bus.s_tready = r;
    #1;
  endtask

  // Advance one clock, updating the model from the rules for the inputs
  // currently applied, then let outputs settle
  task automatic tick();
    logic [M-1:0] na [S];
    logic [M-1:0] ns [S];
    logic [S-1:0] np;
    logic [M-1:0] busy;
    logic acc, sof;
    int src;
    src  = int'(bus.cfg_src);
    busy = '0;
    for (int j = 0; j < S; j++)
      if (j != src) busy |= m_act[j] | (m_pend[j] ? m_shd[j] : '0);
    acc = bus.cfg_wr && (src < S) && ($countones(bus.cfg_bmp) <= 1) && ((bus.cfg_bmp & busy) == '0);
    np = m_pend;
    for (int i = 0; i < S; i++) begin
      na[i] = m_act[i];
      ns[i] = m_shd[i];
      sof = bus.s_tvalid[i] && bus.s_tuser[i];
      if (m_pend[i] && (m_act[i] == '0 || (sof && bus.s_tready[i]) || (m_shd[i] == '0 && sof))) begin
        na[i] = m_shd[i];
        np[i] = 1'b0;
      end
    end
    if (acc) begin
      ns[src] = bus.cfg_bmp;
      np[src] = 1'b1;
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < S; i++) begin m_act[i] = '0; m_shd[i] = '0; end
      m_pend = '0; m_ack = 1'b0; m_err = 1'b0;
    end else begin
      for (int i = 0; i < S; i++) begin m_act[i] = na[i]; m_shd[i] = ns[i]; end
      m_pend = np; m_ack = acc; m_err = bus.cfg_wr && !acc;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 0, '0);
    snoop('0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_dst_bmp !== '0) begin errors++; $display("FAIL reset_bmp: got %h want 0", s_dst_bmp); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
    checks++; if ({bus.cfg_ack, bus.cfg_err} !== 2'b00) begin errors++; $display("FAIL reset_ackerr: got %b want 00", {bus.cfg_ack, bus.cfg_err}); end
  endtask

  task automatic test_attach();
    drive(1'b1, 0, 8'h01);
    tick();
    drive(1'b0, 0, '0);
    checks++; if (bus.cfg_ack !== 1'b1) begin errors++; $display("FAIL attach_ack: got %b want 1", bus.cfg_ack); end
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL attach_pend1: got %b want 1", pending[0]); end
    tick();
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL attach_pend0: got %b want 0", pending[0]); end
    checks++; if (s_dst_bmp[7:0] !== 8'h01) begin errors++; $display("FAIL attach_slice: got %h want 01", s_dst_bmp[7:0]); end
  endtask

  task automatic test_frame_boundary();
    snoop(8'h01, 8'h00, 8'h01);
    drive(1'b1, 0, 8'h02);
    tick();
    drive(1'b0, 0, '0);
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL fb_pend: got %b want 1", pending[0]); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (s_dst_bmp[7:0] !== 8'h01) begin errors++; $display("FAIL fb_midframe: got %h want 01", s_dst_bmp[7:0]); end
    end
    snoop(8'h01, 8'h01, 8'h01);
    checks++; if (s_dst_bmp[7:0] !== 8'h02) begin errors++; $display("FAIL fb_sof_beat: got %h want 02", s_dst_bmp[7:0]); end
    tick();
    checks++; if ({pending[0], s_dst_bmp[7:0]} !== {1'b0, 8'h02}) begin errors++; $display("FAIL fb_commit: got %b/%h want 0/02", pending[0], s_dst_bmp[7:0]); end
    snoop(8'h01, 8'h00, 8'h01);
  endtask

  task automatic test_conflict();
    drive(1'b1, 1, 8'h02);
    tick();
    drive(1'b0, 0, '0);
    checks++; if ({bus.cfg_ack, bus.cfg_err} !== 2'b01) begin errors++; $display("FAIL conf_live_err: got %b want 01", {bus.cfg_ack, bus.cfg_err}); end
    checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL conf_nochange: got %b want 0", pending[1]); end
    drive(1'b1, 0, 8'h04);
    tick();
    drive(1'b0, 0, '0);
    snoop(8'h01, 8'h01, 8'h01);
    tick();
    snoop(8'h01, 8'h00, 8'h01);
    checks++; if (s_dst_bmp[7:0] !== 8'h04) begin errors++; $display("FAIL conf_reroute: got %h want 04", s_dst_bmp[7:0]); end
    drive(1'b1, 1, 8'h02);
    tick();
    drive(1'b0, 0, '0);
    checks++; if (bus.cfg_ack !== 1'b1) begin errors++; $display("FAIL conf_retry_ack: got %b want 1", bus.cfg_ack); end
    tick();
    checks++; if (s_dst_bmp[15:8] !== 8'h02) begin errors++; $display("FAIL conf_retry_slice: got %h want 02", s_dst_bmp[15:8]); end
    // Destination claimed only by an in-flight route is also protected
    drive(1'b1, 0, 8'h20);
    tick();
    drive(1'b1, 4, 8'h20);
    tick();
    drive(1'b0, 0, '0);
    checks++; if ({bus.cfg_ack, bus.cfg_err} !== 2'b01) begin errors++; $display("FAIL conf_inflight_err: got %b want 01", {bus.cfg_ack, bus.cfg_err}); end
    checks++; if (pending !== m_pend) begin errors++; $display("FAIL conf_pending: got %h want %h", pending, m_pend); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 5, 8'h03);
    tick();
    checks++; if ({bus.cfg_ack, bus.cfg_err} !== 2'b01) begin errors++; $display("FAIL ill_multi: got %b want 01", {bus.cfg_ack, bus.cfg_err}); end
    drive(1'b1, 9, 8'h40);
    tick();
    drive(1'b0, 0, '0);
    checks++; if ({bus.cfg_ack, bus.cfg_err} !== 2'b01) begin errors++; $display("FAIL ill_src: got %b want 01", {bus.cfg_ack, bus.cfg_err}); end
    checks++; if (pending[5] !== 1'b0) begin errors++; $display("FAIL ill_nochange: got %b want 0", pending[5]); end
  endtask

  task automatic test_detach();
    do_reset();
    drive(1'b1, 2, 8'h04);
    tick();
    drive(1'b0, 0, '0);
    tick();
    checks++; if (s_dst_bmp[23:16] !== 8'h04) begin errors++; $display("FAIL det_live: got %h want 04", s_dst_bmp[23:16]); end
    drive(1'b1, 2, 8'h00);
    tick();
    drive(1'b0, 0, '0);
    checks++; if ({bus.cfg_ack, pending[2]} !== 2'b11) begin errors++; $display("FAIL det_ack: got %b want 11", {bus.cfg_ack, pending[2]}); end
    snoop(8'h04, 8'h04, 8'h00);
    tick();
    checks++; if ({pending[2], s_dst_bmp[23:16]} !== {1'b0, 8'h00}) begin errors++; $display("FAIL det_commit: got %b/%h want 0/00", pending[2], s_dst_bmp[23:16]); end
    snoop('0, '0, '0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 0, 8'h01);
    tick();
    drive(1'b0, 0, '0);
    tick();
    drive(1'b1, 0, 8'h02);
    tick();
    snoop(8'h01, 8'h01, 8'h01);
    drive(1'b1, 0, 8'h08);
    tick();
    drive(1'b0, 0, '0);
    snoop(8'h01, 8'h00, 8'h01);
    checks++; if ({pending[0], s_dst_bmp[7:0]} !== {1'b1, 8'h02}) begin errors++; $display("FAIL b2b_state: got %b/%h want 1/02", pending[0], s_dst_bmp[7:0]); end
    snoop(8'h01, 8'h01, 8'h00);
    checks++; if (s_dst_bmp[7:0] !== 8'h08) begin errors++; $display("FAIL b2b_shadow: got %h want 08", s_dst_bmp[7:0]); end
    snoop(8'h01, 8'h00, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({pending, s_dst_bmp} !== '0) begin errors++; $display("FAIL b2b_midreset: got %h/%h want 0", pending, s_dst_bmp); end
  endtask

  task automatic test_random();
    logic [M-1:0] bmp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      case ($urandom % 4)
        0:       bmp = '0;
        1, 2:    bmp = M'(1) << ($urandom % M);
        default: bmp = M'($urandom);
      endcase
      drive(1'($urandom % 2), int'($urandom_range(0, 9)), bmp);
      bus.s_tvalid = S'($urandom);
      bus.s_tuser  = S'($urandom) & S'($urandom);
      bus.s_tready = S'($urandom);
      reset = (($urandom % 150) == 0);
      #1;
      checks++; if (s_dst_bmp !== exp_bmp()) begin errors++; $display("FAIL rnd_bmp_pre[%0d]: got %h want %h", n, s_dst_bmp, exp_bmp()); end
      tick();
      checks++; if ({bus.cfg_ack, bus.cfg_err} !== {m_ack, m_err}) begin errors++; $display("FAIL rnd_ackerr[%0d]: got %b want %b", n, {bus.cfg_ack, bus.cfg_err}, {m_ack, m_err}); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending[%0d]: got %h want %h", n, pending, m_pend); end
      checks++; if (s_dst_bmp !== exp_bmp()) begin errors++; $display("FAIL rnd_bmp[%0d]: got %h want %h", n, s_dst_bmp, exp_bmp()); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 0, '0);
    bus.s_tvalid = '0;
    bus.s_tuser  = '0;
    bus.s_tready = '0;
    for (int i = 0; i < S; i++) begin m_act[i] = '0; m_shd[i] = '0; end
    m_pend = '0; m_ack = 1'b0; m_err = 1'b0;
    test_reset();
    test_attach();
    test_frame_boundary();
    test_conflict();
    test_illegal();
    test_detach();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
